// File: rtl/downsample_strobe_ctrl.sv
// Strobe sequencer for a decimating line buffer: tracks pixel coordinates within a
// frame and produces the column-sample strobe (xs) and the sampled-row level (ys).
module downsample_strobe_ctrl #(
   parameter int BUF_LEN = 100,
   parameter int CNT_W   = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_height,
   input  logic [1:0]       cfg_shift,
   input  logic             frame_start,
   input  logic             pix_valid,
   output logic             xs,
   output logic             ys,
   output logic [CNT_W-1:0] x_cnt,
   output logic [CNT_W-1:0] y_cnt,
   output logic             busy,
   output logic             frame_done,
   output logic             cfg_err
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W:0]   BUF_LEN_X = (CNT_W+1)'(BUF_LEN);
   localparam logic [CNT_W-1:0] RST_DIM   = CNT_W'(BUF_LEN);

   state_t           state_q, state_n;
   logic [CNT_W-1:0] x_q, x_n, y_q, y_n;
   logic [CNT_W-1:0] w_q, w_n, h_q, h_n;
   logic [1:0]       s_q, s_n;
   logic             done_n, err_n;
   logic             cfg_ok, load_ok, active;
   logic [CNT_W-1:0] cur_x, cur_y, eff_w, eff_h, mask;

   // Number of sampled columns for a line of width v decimated by 2^s.
   function automatic logic [CNT_W:0] ceil_shr(input logic [CNT_W-1:0] v,
                                                input logic [1:0]       s);
      logic [CNT_W:0] ext;
      ext = {1'b0, v} + ((CNT_W+1)'(1) << s) - (CNT_W+1)'(1);
      return ext >> s;
   endfunction

   assign cfg_ok  = (cfg_width != '0) && (cfg_height != '0) &&
                    (ceil_shr(cfg_width, cfg_shift) <= BUF_LEN_X);
   assign load_ok = (state_q == IDLE) && cfg_load && cfg_ok;
   // A config loaded together with frame_start governs the wrap compares of pixel (0,0).
   assign eff_w   = load_ok ? cfg_width  : w_q;
   assign eff_h   = load_ok ? cfg_height : h_q;

   assign active = !rst && ((state_q == RUN) || frame_start);
   assign cur_x  = (rst || frame_start) ? '0 : x_q;
   assign cur_y  = (rst || frame_start) ? '0 : y_q;
   assign mask   = ~({CNT_W{1'b1}} << s_q);

   assign xs    = active && pix_valid && ((cur_x & mask) == '0);
   assign ys    = active && ((cur_y & mask) == '0);
   assign x_cnt = cur_x;
   assign y_cnt = cur_y;
   assign busy  = (state_q == RUN);

   always_comb begin
      state_n = state_q;
      x_n     = x_q;
      y_n     = y_q;
      w_n     = w_q;
      h_n     = h_q;
      s_n     = s_q;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if ((state_q == IDLE) && cfg_load) begin
         if (cfg_ok) begin
            w_n = cfg_width;
            h_n = cfg_height;
            s_n = cfg_shift;
         end else begin
            err_n = 1'b1;
         end
      end
      if (active) begin
         state_n = RUN;
         x_n     = cur_x;
         y_n     = cur_y;
         if (pix_valid) begin
            if (cur_x == eff_w - CNT_W'(1)) begin
               x_n = '0;
               if (cur_y == eff_h - CNT_W'(1)) begin
                  y_n     = '0;
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  y_n = cur_y + CNT_W'(1);
               end
            end else begin
               x_n = cur_x + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         w_q        <= RST_DIM;
         h_q        <= RST_DIM;
         s_q        <= 2'd0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state_q    <= state_n;
         x_q        <= x_n;
         y_q        <= y_n;
         w_q        <= w_n;
         h_q        <= h_n;
         s_q        <= s_n;
         frame_done <= done_n;
         cfg_err    <= err_n;
      end
   end

endmodule

// File: doc/downsample_strobe_ctrl.md
DOWNSAMPLE_STROBE_CTRL -- requirements
Module: downsample_strobe_ctrl

Interface
REQ-001 The block SHALL have parameter BUF_LEN, default 100, giving the sampled-column capacity of the line buffer being sequenced.
REQ-002 The block SHALL have parameter CNT_W, default 11, giving the width/height counter width.
REQ-003 Port clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1  synchronous active-high reset.
REQ-005 Port cfg_load  in  1  request to latch cfg_width/cfg_height/cfg_shift.
REQ-006 Port cfg_width  in  CNT_W  pixels per line.
REQ-007 Port cfg_height  in  CNT_W  lines per frame.
REQ-008 Port cfg_shift  in  2  decimation factor F = 1<<cfg_shift (1, 2, 4, 8).
REQ-009 Port frame_start  in  1  single-cycle start-of-frame marker.
REQ-010 Port pix_valid  in  1  input pixel present this cycle.
REQ-011 Port xs  out  1  column-sample strobe (line-buffer shift enable).
REQ-012 Port ys  out  1  row-sample level (1 = current line is a sampled line).
REQ-013 Port x_cnt  out  CNT_W; port y_cnt  out  CNT_W  coordinates of the pixel currently at the input.
REQ-014 Port busy  out  1; port frame_done  out  1; port cfg_err  out  1.

Function
REQ-015 States SHALL be IDLE and RUN; busy SHALL equal 1 exactly in RUN.
REQ-016 Active config SHALL be (width, height, shift); cfg_load SHALL be honoured only in IDLE and ignored in RUN (no cfg_err).
REQ-017 A config SHALL be rejected when width==0, height==0, or ceil(width/F) > BUF_LEN; rejection SHALL pulse cfg_err for one cycle (registered, cycle after cfg_load) and retain the previous config.
REQ-018 An accepted config SHALL take effect the cycle after cfg_load; cfg_load and frame_start together in IDLE SHALL start the frame with the new config if accepted, else the old one.
REQ-019 IDLE -> RUN on frame_start; counters SHALL be treated as (0,0) in that cycle, and pix_valid in that cycle SHALL be pixel (0,0).
REQ-020 In RUN each cycle with pix_valid SHALL advance x_cnt; at x_cnt==width-1, x_cnt wraps to 0 and y_cnt increments.
REQ-021 On the pixel with x_cnt==width-1 and y_cnt==height-1, the block SHALL return to IDLE and pulse frame_done for one cycle on the following cycle.
REQ-022 frame_start in RUN SHALL abort the frame: counters restart at (0,0) for that cycle, state stays RUN, no frame_done.
REQ-023 xs SHALL be combinational, zero latency: xs = pix_valid AND (RUN or frame_start) AND (x_cnt low cfg_shift bits == 0).
REQ-024 ys SHALL be combinational: ys = (RUN or frame_start) AND (y_cnt low cfg_shift bits == 0); ys SHALL be 0 in IDLE.
REQ-025 pix_valid in IDLE without frame_start SHALL be ignored: xs=0, counters unchanged.
REQ-026 Counters SHALL not advance on cycles without pix_valid; gaps of any length SHALL be tolerated.
REQ-027 Counter arithmetic SHALL be unsigned CNT_W-bit; wrap SHALL only occur via REQ-020 compare, never overflow.
REQ-028 Sampled columns per line SHALL equal ceil(width/F), i.e. xs count per line never exceeds BUF_LEN for an accepted config.

Reset
REQ-029 rst SHALL force IDLE, x_cnt=0, y_cnt=0, xs=0, ys=0, busy=0, frame_done=0, cfg_err=0, config = (BUF_LEN, BUF_LEN, 0).
REQ-030 rst asserted mid-frame SHALL take priority over all inputs, including frame_start and cfg_load in the same cycle, and SHALL suppress frame_done.

Verification
REQ-031 cfg (width=8,height=4,shift=1), frame_start, 32 contiguous pix_valid -> xs high at x=0,2,4,6 per line (16 total), ys high on lines 0 and 2, frame_done one cycle after pixel 32, busy low after.
REQ-032 cfg width=201,shift=1 with BUF_LEN=100 -> cfg_err pulse, next frame uses previous config; width=200 -> accepted, no cfg_err.
REQ-033 Random pix_valid gaps (50% duty) over an 8x4 frame -> identical xs/ys/coordinate sequence as contiguous case, frame_done after 32nd valid pixel.
REQ-034 frame_start asserted at pixel (5,2) -> that pixel reported as (0,0), xs=1, ys=1, no frame_done for aborted frame.
REQ-035 rst at pixel (3,1) with frame_start same cycle -> IDLE, counters 0, busy=0, no frame_done; cfg_load during RUN -> ignored, cfg_err stays 0.
